// File: rtl/sop_error_sweep_ctrl_pkg.sv
// Shared types and helpers for the SOP error-sweep checker.
// Holds the sweep FSM state encoding and the unsigned absolute-difference helper.
package sop_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

    // Operands are zero-extended to this width, so datapath outputs up to 16 bits fit.
    localparam int ABS_W = 16;

    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sop_error_sweep_ctrl_if.sv
// Handshake/result bundle between the sweep controller and the datapath under test.
// Define SWEEP_SUM_ERR_EN to carry the accumulated-error result as well.
interface sop_error_sweep_ctrl_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
);
    logic               start;
    logic               abort;
    logic [N_OUT-1:0]   exact_i;
    logic [N_OUT-1:0]   approx_i;
    logic [N_IN-1:0]    vec_o;
    logic               busy;
    logic               done;
    logic [N_OUT-1:0]   max_err_o;
    logic [N_IN-1:0]    wc_vec_o;
    logic               violation;
    logic [N_IN:0]      viol_cnt_o;
`ifdef SWEEP_SUM_ERR_EN
    logic [N_OUT+N_IN-1:0] sum_err_o;

    modport master (
        output start, abort, exact_i, approx_i,
        input  vec_o, busy, done, max_err_o, wc_vec_o, violation, viol_cnt_o, sum_err_o
    );
    modport slave (
        input  start, abort, exact_i, approx_i,
        output vec_o, busy, done, max_err_o, wc_vec_o, violation, viol_cnt_o, sum_err_o
    );
`else
    modport master (
        output start, abort, exact_i, approx_i,
        input  vec_o, busy, done, max_err_o, wc_vec_o, violation, viol_cnt_o
    );
    modport slave (
        input  start, abort, exact_i, approx_i,
        output vec_o, busy, done, max_err_o, wc_vec_o, violation, viol_cnt_o
    );
`endif
endinterface

// File: rtl/sop_error_sweep_ctrl_abs_err_unit.sv
// Purpose: |a - b| of two unsigned datapath outputs.
// Latency: combinational. Backpressure: none.
module abs_err_unit
    import sop_sweep_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] err
);

    // The difference of two W-bit unsigned values always fits in W bits.
    assign err = W'(abs_diff(ABS_W'(a), ABS_W'(b)));

endmodule

// File: rtl/sop_error_sweep_ctrl.sv
// Purpose: exhaustive 2**N_IN sweep of exact vs approximate SOP outputs; tracks max/worst vector/violations.
// Latency: LAT+1 cycles per vector, done 2**N_IN*(LAT+1)+1 cycles after start. Backpressure: none; abort stops early.
// Option: SWEEP_SUM_ERR_EN adds sum_err_o, the total absolute error over the sweep.
module sop_error_sweep_ctrl
    import sop_sweep_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 3,
    parameter int LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    sop_error_sweep_ctrl_if.slave   bus
);

    localparam int                CW       = (LAT > 1) ? $clog2(LAT + 1) : 1;
    localparam logic [N_IN-1:0]   LAST_VEC = '1;
    localparam logic [N_OUT-1:0]  ET_V     = N_OUT'(ET);
    localparam sweep_state_t      VEC_ST   = (LAT == 0) ? CMP : WAIT;

    sweep_state_t       state;
    logic [CW-1:0]      wait_cnt;
    logic [N_IN-1:0]    vec;
    logic               busy;
    logic               done;
    logic [N_OUT-1:0]   max_err;
    logic [N_IN-1:0]    wc_vec;
    logic               violation;
    logic [N_IN:0]      viol_cnt;
    logic [N_OUT-1:0]   err;
`ifdef SWEEP_SUM_ERR_EN
    logic [N_OUT+N_IN-1:0] sum_err;
`endif

    abs_err_unit #(.W(N_OUT)) u_abs_err (
        .a   (bus.exact_i),
        .b   (bus.approx_i),
        .err (err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            max_err   <= '0;
            wc_vec    <= '0;
            violation <= 1'b0;
            viol_cnt  <= '0;
`ifdef SWEEP_SUM_ERR_EN
            sum_err   <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Abort beats every in-sweep action, including the DONE pulse.
            if (state != IDLE && bus.abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            vec       <= '0;
                            max_err   <= '0;
                            wc_vec    <= '0;
                            violation <= 1'b0;
                            viol_cnt  <= '0;
`ifdef SWEEP_SUM_ERR_EN
                            sum_err   <= '0;
`endif
                            busy      <= 1'b1;
                            wait_cnt  <= CW'(LAT);
                            state     <= VEC_ST;
                        end
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt - 1'b1;
                        if (wait_cnt <= CW'(1)) begin
                            state <= CMP;
                        end
                    end
                    CMP: begin
                        if (err > max_err) begin
                            max_err <= err;
                            wc_vec  <= vec;
                        end
                        if (err > ET_V) begin
                            viol_cnt  <= viol_cnt + (N_IN+1)'(1);
                            violation <= 1'b1;
                        end
`ifdef SWEEP_SUM_ERR_EN
                        sum_err <= sum_err + (N_OUT+N_IN)'(err);
`endif
                        if (vec == LAST_VEC) begin
                            state <= DONE;
                        end else begin
                            vec      <= vec + 1'b1;
                            wait_cnt <= CW'(LAT);
                            state    <= VEC_ST;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.vec_o      = vec;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.max_err_o  = max_err;
    assign bus.wc_vec_o   = wc_vec;
    assign bus.violation  = violation;
    assign bus.viol_cnt_o = viol_cnt;
`ifdef SWEEP_SUM_ERR_EN
    assign bus.sum_err_o  = sum_err;
`endif

endmodule

// File: tb/tb_sop_error_sweep_ctrl.sv
// Bench for sop_error_sweep_ctrl: a LAT=1 instance with a registered datapath model
// and a LAT=0 instance with a combinational one; results checked against a scoreboard.
module tb_sop_error_sweep_ctrl;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int ET    = 3;

    typedef struct {
        int max_err;
        int wc;
        int viol;
        int cnt;
        int sum;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sop_error_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus1 ();
    sop_error_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus2 ();

    sop_error_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    sop_error_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .LAT(0)) dut_lat0 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int         checks = 0;
    int         errors = 0;
    int         mode1  = 0;
    logic [2:0] rnd [16];
    res_t       sb [$];

    function automatic logic [2:0] f_exact(input logic [3:0] v);
        int t;
        t = int'(v) * 5 + 3;
        return 3'(t % 8);
    endfunction

    function automatic logic [2:0] f_approx(input int mode, input logic [3:0] v);
        logic [2:0] e;
        e = f_exact(v);
        case (mode)
            1:       return (v == 4'd9) ? (e ^ 3'b100) : e;
            2:       return (e >= 3'd3) ? (e - 3'd3) : (e + 3'd3);
            3:       return rnd[v];
            4:       return (e == 3'd0) ? 3'd1 : (e - 3'd1);
            default: return e;
        endcase
    endfunction

    // Reference sweep over the first nvec vectors.
    function automatic res_t model(input int mode, input int nvec);
        res_t r;
        int   d;
        r = '{0, 0, 0, 0, 0};
        for (int v = 0; v < nvec; v++) begin
            d = int'(f_exact(4'(v))) - int'(f_approx(mode, 4'(v)));
            if (d < 0) d = -d;
            if (d > r.max_err) begin
                r.max_err = d;
                r.wc      = v;
            end
            if (d > ET) begin
                r.cnt++;
                r.viol = 1;
            end
            r.sum += d;
        end
        return r;
    endfunction

    // One-cycle-latency datapath for the LAT=1 instance.
    logic [2:0] ex1_q, ap1_q;
    always @(posedge clk) begin
        ex1_q <= f_exact(bus1.vec_o);
        ap1_q <= f_approx(mode1, bus1.vec_o);
    end
    assign bus1.exact_i  = ex1_q;
    assign bus1.approx_i = ap1_q;
    assign bus2.exact_i  = f_exact(bus2.vec_o);
    assign bus2.approx_i = f_approx(4, bus2.vec_o);

    // Runs one sweep on the LAT=1 instance; n counts edges after the one that sampled start.
    task automatic run1(input int mode, input int restart_at, input int abort_at,
                        output int done_at, output int busy_low_at);
        done_at     = -1;
        busy_low_at = -1;
        mode1       = mode;
        @(negedge clk);
        bus1.start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus1.done === 1'b1 && done_at < 0) done_at = n;
            if (bus1.busy === 1'b0 && busy_low_at < 0) busy_low_at = n;
            bus1.start = (n + 1 == restart_at);
            bus1.abort = (n + 1 == abort_at);
            if (busy_low_at >= 0) break;
        end
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus1.vec_o, bus1.busy, bus1.done, bus1.max_err_o, bus1.wc_vec_o,
             bus1.violation, bus1.viol_cnt_o} !== 19'd0) begin
            errors++;
            $display("FAIL reset_lat1: outputs=%h required 0", {bus1.vec_o, bus1.busy, bus1.done,
                     bus1.max_err_o, bus1.wc_vec_o, bus1.violation, bus1.viol_cnt_o});
        end
        checks++;
        if ({bus2.vec_o, bus2.busy, bus2.done, bus2.max_err_o, bus2.wc_vec_o,
             bus2.violation, bus2.viol_cnt_o} !== 19'd0) begin
            errors++;
            $display("FAIL reset_lat0: outputs=%h required 0", {bus2.vec_o, bus2.busy, bus2.done,
                     bus2.max_err_o, bus2.wc_vec_o, bus2.violation, bus2.viol_cnt_o});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sweep(input string name, input int mode, input int restart_at);
        int   d_at, b_at;
        res_t e;
        sb.push_back(model(mode, 16));
        run1(mode, restart_at, 0, d_at, b_at);
        checks++;
        if (d_at !== 33) begin
            errors++;
            $display("FAIL %s_done_time: got %0d required 33", name, d_at);
        end
        checks++;
        if (b_at !== 33) begin
            errors++;
            $display("FAIL %s_busy_time: got %0d required 33", name, b_at);
        end
        e = sb.pop_front();
        checks++;
        if ({bus1.max_err_o, bus1.wc_vec_o, bus1.violation, bus1.viol_cnt_o} !==
            {3'(e.max_err), 4'(e.wc), 1'(e.viol), 5'(e.cnt)}) begin
            errors++;
            $display("FAIL %s_results: max=%0d wc=%0d viol=%0d cnt=%0d required max=%0d wc=%0d viol=%0d cnt=%0d",
                     name, bus1.max_err_o, bus1.wc_vec_o, bus1.violation, bus1.viol_cnt_o,
                     e.max_err, e.wc, e.viol, e.cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.max_err_o, bus1.wc_vec_o, bus1.violation, bus1.viol_cnt_o, bus1.done} !==
            {3'(e.max_err), 4'(e.wc), 1'(e.viol), 5'(e.cnt), 1'b0}) begin
            errors++;
            $display("FAIL %s_hold: results/done changed after completion", name);
        end
    endtask

    task automatic test_abort_restart();
        int   d_at, b_at;
        res_t e;
        run1(3, 0, 10, d_at, b_at);
        checks++;
        if (b_at !== 10) begin
            errors++;
            $display("FAIL abort_busy_time: got %0d required 10", b_at);
        end
        checks++;
        if (d_at !== -1) begin
            errors++;
            $display("FAIL abort_no_done: done seen at %0d required none", d_at);
        end
        e = model(3, 4);
        checks++;
        if ({bus1.max_err_o, bus1.wc_vec_o, bus1.violation, bus1.viol_cnt_o} !==
            {3'(e.max_err), 4'(e.wc), 1'(e.viol), 5'(e.cnt)}) begin
            errors++;
            $display("FAIL abort_partial: max=%0d wc=%0d viol=%0d cnt=%0d required max=%0d wc=%0d viol=%0d cnt=%0d",
                     bus1.max_err_o, bus1.wc_vec_o, bus1.violation, bus1.viol_cnt_o,
                     e.max_err, e.wc, e.viol, e.cnt);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL abort_idle: done=%b busy=%b required 0/0", bus1.done, bus1.busy);
                break;
            end
        end
        test_sweep("restart", 3, 0);
    endtask

    task automatic test_rst_midsweep();
        mode1 = 3;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus1.vec_o, bus1.busy, bus1.done, bus1.max_err_o, bus1.wc_vec_o,
             bus1.violation, bus1.viol_cnt_o} !== 19'd0) begin
            errors++;
            $display("FAIL rst_midsweep: outputs=%h required 0", {bus1.vec_o, bus1.busy, bus1.done,
                     bus1.max_err_o, bus1.wc_vec_o, bus1.violation, bus1.viol_cnt_o});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lat0();
        int   d_at;
        res_t e;
        d_at = -1;
        sb.push_back(model(4, 16));
        @(negedge clk);
        bus2.start = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            if (bus2.done === 1'b1) begin
                d_at = n;
                break;
            end
        end
        checks++;
        if (d_at !== 17) begin
            errors++;
            $display("FAIL lat0_done_time: got %0d required 17", d_at);
        end
        e = sb.pop_front();
        checks++;
        if ({bus2.max_err_o, bus2.wc_vec_o, bus2.violation, bus2.viol_cnt_o} !==
            {3'(e.max_err), 4'(e.wc), 1'(e.viol), 5'(e.cnt)}) begin
            errors++;
            $display("FAIL lat0_results: max=%0d wc=%0d viol=%0d cnt=%0d required max=%0d wc=%0d viol=%0d cnt=%0d",
                     bus2.max_err_o, bus2.wc_vec_o, bus2.violation, bus2.viol_cnt_o,
                     e.max_err, e.wc, e.viol, e.cnt);
        end
`ifdef SWEEP_SUM_ERR_EN
        checks++;
        if (bus2.sum_err_o !== 7'(e.sum)) begin
            errors++;
            $display("FAIL lat0_sum_err: got %0d required %0d", bus2.sum_err_o, e.sum);
        end
`endif
    endtask

    initial begin
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        for (int i = 0; i < 16; i++) rnd[i] = 3'($urandom_range(0, 7));
        rnd[1] = 3'd7;
        test_reset();
        test_sweep("exact_match", 0, 0);
        test_sweep("single_vec9", 1, 0);
        test_sweep("err_eq_et", 2, 0);
        test_abort_restart();
        test_sweep("back_to_back", 2, 8);
        test_lat0();
        test_rst_midsweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
